instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front end of the 9-bit accumulator-style core.
- Holds the program counter and fetches 9-bit instructions from instruction memory over a req/ack handshake.
- Splits each instruction into the fields the Controller decodes (msb, opCode, operand) and issues them with a valid/ready handshake.
- Redirects the PC on a taken BNE, using the `bne` flag returned by the Controller and the datapath not-equal flag.

Parameters:
- PC_W, 8: program counter and instruction address width.
- START_PC, 0: PC value loaded on reset.
- TIMEOUT, 15: maximum cycles to wait for `imem_ack`. Used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: begins execution from the current PC while in IDLE.
- imem_req, out, 1: fetch request.
- imem_addr, out, PC_W: fetch address; always equals `pc`.
- imem_ack, in, 1: `imem_data` is valid this cycle.
- imem_data, in, 9: fetched instruction.
- msb, out, 1: instruction bit 8 (SET flag to the Controller).
- opCode, out, 3: instruction bits 7:5.
- operand, out, 5: instruction bits 4:0 (register index, immediate, or branch offset).
- issue_valid, out, 1: an instruction is presented to decode/execute.
- issue_ready, in, 1: execute accepts the presented instruction.
- bne, in, 1: Controller decode of the presented instruction; sampled on accept.
- not_equal, in, 1: datapath compare result; sampled on accept.
- pc, out, PC_W: current program counter.
- done, out, 1: HALT reached; held until reset.
- fetch_err, out, 1: timeout error. Present only with FETCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, pc = START_PC.
  - Instruction register cleared, so msb, opCode and operand are all 0.
  - imem_req, issue_valid, done and fetch_err are all 0.
  - A reset mid-fetch or mid-issue abandons the transaction. A late `imem_ack` after reset is ignored, because the unit is in IDLE.
- State machine (4 states: IDLE, FETCH, ISSUE, HALT):
  - IDLE: all handshake outputs low. `start` = 1 moves to FETCH next cycle. `start` is ignored in every other state.
  - FETCH:
    - imem_req = 1 and imem_addr = pc, held stable until ack.
    - On imem_ack = 1, latch imem_data into the instruction register.
    - If imem_data = 9'h1FF (HALT), go to HALT; otherwise go to ISSUE.
    - imem_req drops the cycle after ack. Minimum fetch latency is 1 cycle (ack in the first FETCH cycle).
  - ISSUE:
    - issue_valid = 1. msb, opCode and operand are driven from the instruction register and held stable while issue_ready = 0.
    - On issue_valid & issue_ready, the next pc is:
      - pc + sign_extend(operand) if bne & not_equal;
      - otherwise pc + 1.
    - All PC arithmetic is modulo 2^PC_W: 0xFF + 1 = 0x00, and 0x02 + (-4) = 0xFE.
    - After accept, return to FETCH; issue_valid is low for at least one cycle.
    - Throughput is one instruction per 2 cycles when ack and ready are both immediate.
  - HALT: done = 1 and pc is frozen. HALT is never issued. Only reset leaves this state.
- bne and not_equal are don't-care unless issue_valid & issue_ready.
- A branch offset of 0 means an infinite loop at the same pc. This is legal and must not be flagged.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) runs during FETCH and clears on ack.
  - If TIMEOUT cycles pass with no ack, go to HALT and set fetch_err = 1 (sticky until reset); done = 1 as well.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins; no error.
- Not defined: the unit waits indefinitely in FETCH, and the fetch_err port and counter do not exist.

Decomposition:
- Add to package `definitions`:
  - enum typedef fetch_state_t {IDLE, FETCH, ISSUE, HALT};
  - localparam INSTR_W = 9;
  - localparam HALT_INSTR = 9'h1FF;
  - struct typedef instr_fields_t {msb, opCode[2:0], operand[4:0]}.
- One sub-module is natural: `pc_next`, a combinational next-PC adder/selector (increment vs signed-offset branch, modulo wrap). It is unit-testable in isolation.
- The FSM and instruction register stay in the top level.

Test Plan:
- Reset, START_PC = 0, pulse start; memory acks immediately with 9'h041, ready = 1 → issue msb = 0, opCode = 3'b010, operand = 5'h01; pc goes 0 → 1.
- Memory acks after 3 cycles → imem_req high for exactly 3 cycles, imem_addr stable; issue_valid held with stable fields while ready is 0 for 2 cycles.
- At pc = 0x05, issue operand 5'b11100 (-4) with bne = 1, not_equal = 1 → next imem_addr = 0x01. Same instruction with not_equal = 0 → next address 0x06.
- pc = 0xFF with no branch → next fetch address 0x00. Branch at 0x02 with offset -4 → 0xFE.
- Fetch returns 9'h1FF → issue_valid never asserts, done = 1, pc frozen; start pulses are ignored; reset returns to IDLE with pc = START_PC.
- With FETCH_TIMEOUT_EN: no ack for 15 cycles → fetch_err = 1 and done = 1. Ack exactly on cycle 15 → no error, normal issue.

Source files
------------

// File: rtl/definitions.sv
// Shared types and constants for the instruction fetch front end.
package definitions;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } fetch_state_t;

    localparam int INSTR_W = 9;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    typedef struct packed {
        logic       msb;
        logic [2:0] opCode;
        logic [4:0] operand;
    } instr_fields_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selector: pc + 1, or pc + sign-extended 5-bit offset when the branch is taken.
// All arithmetic wraps modulo 2^PC_W.
module pc_next #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [4:0]      offset,
    input  logic            take,
    output logic [PC_W-1:0] next
);

    logic [PC_W-1:0] offset_ext;

    assign offset_ext = {{(PC_W-5){offset[4]}}, offset};
    assign next       = take ? (pc + offset_ext) : (pc + {{(PC_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue front end of the 9-bit accumulator core: PC, fetch handshake, decode fields, BNE redirect.
// Optional FETCH_TIMEOUT_EN adds a fetch watchdog that halts with a sticky fetch_err.
module instr_fetch_unit
    import definitions::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               msb,
    output logic [2:0]         opCode,
    output logic [4:0]         operand,
    output logic               issue_valid,
    input  logic               issue_ready,
    input  logic               bne,
    input  logic               not_equal,
    output logic [PC_W-1:0]    pc,
`ifdef FETCH_TIMEOUT_EN
    output logic               fetch_err,
`endif
    output logic               done
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_nxt;
    instr_fields_t   ir_q;
    logic            ir_load, pc_load;

`ifdef FETCH_TIMEOUT_EN
    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q;
    logic             timeout;
    logic             fetch_err_q;
`endif

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc     (pc_q),
        .offset (ir_q.operand),
        .take   (bne & not_equal),
        .next   (pc_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pc_load) pc_q <= pc_nxt;
            if (ir_load) ir_q <= instr_fields_t'(imem_data);
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        imem_req    = 1'b0;
        issue_valid = 1'b0;
        done        = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timeout     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = (imem_data == HALT_INSTR) ? HALT : ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                // An ack in the terminal cycle takes priority over the watchdog.
                else if (tmr_q == '0) begin
                    timeout = 1'b1;
                    state_d = HALT;
                end
`endif
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
            HALT: begin
                done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q       <= TMR_INIT;
            fetch_err_q <= 1'b0;
        end else begin
            if (state_q != FETCH || imem_ack) tmr_q <= TMR_INIT;
            else if (tmr_q != '0)             tmr_q <= tmr_q - 1'b1;
            if (timeout) fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`endif

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign msb       = ir_q.msb;
    assign opCode    = ir_q.opCode;
    assign operand   = ir_q.operand;

endmodule
